// File: rtl/desc_offset_walker.sv
// Walks the 256-entry descriptor offset ROMs and streams keypoint-relative sample coordinates.
// Optional build macro DESC_OFFSET_CLAMP_EN saturates smp_x/smp_y to the image bounds.
module desc_offset_walker #(
  parameter int COORD_W = 11,
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COORD_W-1:0] kp_x,
  input  logic [COORD_W-1:0] kp_y,
  output logic               busy,
  output logic [7:0]         rom_a,
  input  logic [4:0]         rom_spo_x,
  input  logic [4:0]         rom_spo_y,
  output logic               smp_valid,
  input  logic               smp_ready,
  output logic [COORD_W-1:0] smp_x,
  output logic [COORD_W-1:0] smp_y,
  output logic [7:0]         smp_idx,
  output logic               smp_oob,
  output logic               smp_last,
  output logic               done
);

  // state | meaning
  // IDLE  | waiting for start; outputs idle, idx parked at 0
  // RUN   | walking idx 0..255, loading the output register as the consumer allows
  // DRAIN | idx 255 loaded; waiting for its handshake, then pulse done
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int SW = COORD_W + 2;
  localparam logic signed [SW-1:0] IMG_W_S = SW'(IMG_W);
  localparam logic signed [SW-1:0] IMG_H_S = SW'(IMG_H);
`ifdef DESC_OFFSET_CLAMP_EN
  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(IMG_H - 1);
`endif

  state_t             state_q, state_d;
  logic [7:0]         idx_q, idx_d;
  logic [COORD_W-1:0] kpx_q, kpx_d;
  logic [COORD_W-1:0] kpy_q, kpy_d;
  logic               valid_q, valid_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic [7:0]         sidx_q, sidx_d;
  logic               oob_q, oob_d;
  logic               last_q, last_d;
  logic               done_q, done_d;

  logic signed [SW-1:0] sx, sy;
  logic [COORD_W-1:0]   x_nxt, y_nxt;
  logic                 oob_nxt;

  // Offsets are sign-extended onto a zero-extended coordinate so under/overflow stays visible.
  always_comb begin
    sx = $signed({2'b00, kpx_q}) + $signed({{(SW-5){rom_spo_x[4]}}, rom_spo_x});
    sy = $signed({2'b00, kpy_q}) + $signed({{(SW-5){rom_spo_y[4]}}, rom_spo_y});
    oob_nxt = (sx < 0) || (sx >= IMG_W_S) || (sy < 0) || (sy >= IMG_H_S);
`ifdef DESC_OFFSET_CLAMP_EN
    if (sx < 0)             x_nxt = '0;
    else if (sx >= IMG_W_S) x_nxt = X_MAX;
    else                    x_nxt = sx[COORD_W-1:0];
    if (sy < 0)             y_nxt = '0;
    else if (sy >= IMG_H_S) y_nxt = Y_MAX;
    else                    y_nxt = sy[COORD_W-1:0];
`else
    x_nxt = sx[COORD_W-1:0];
    y_nxt = sy[COORD_W-1:0];
`endif
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    kpx_d   = kpx_q;
    kpy_d   = kpy_q;
    valid_d = valid_q;
    x_d     = x_q;
    y_d     = y_q;
    sidx_d  = sidx_q;
    oob_d   = oob_q;
    last_d  = last_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          kpx_d   = kp_x;
          kpy_d   = kp_y;
          idx_d   = 8'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!valid_q || smp_ready) begin
          valid_d = 1'b1;
          x_d     = x_nxt;
          y_d     = y_nxt;
          sidx_d  = idx_q;
          oob_d   = oob_nxt;
          last_d  = (idx_q == 8'hFF);
          // idx never wraps: it parks at 255 until the walk ends
          if (idx_q == 8'hFF) state_d = DRAIN;
          else                idx_d   = idx_q + 8'd1;
        end
      end
      DRAIN: begin
        if (valid_q && smp_ready && last_q) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          idx_d   = 8'd0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 8'd0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      kpx_q   <= '0;
      kpy_q   <= '0;
      valid_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      sidx_q  <= '0;
      oob_q   <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      kpx_q   <= kpx_d;
      kpy_q   <= kpy_d;
      valid_q <= valid_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sidx_q  <= sidx_d;
      oob_q   <= oob_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  // busy stays up through the done cycle, when the FSM is already back in IDLE
  assign busy      = (state_q != IDLE) || done_q;
  assign rom_a     = idx_q;
  assign smp_valid = valid_q;
  assign smp_x     = x_q;
  assign smp_y     = y_q;
  assign smp_idx   = sidx_q;
  assign smp_oob   = oob_q;
  assign smp_last  = last_q;
  assign done      = done_q;

endmodule

// File: tb/tb_desc_offset_walker.sv
// Bench for desc_offset_walker: ROM model, scoreboard of expected samples, table of walks.
// Honours DESC_OFFSET_CLAMP_EN the same way the design does.
module tb_desc_offset_walker;
`ifdef DESC_OFFSET_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [10:0] kp_x = '0;
  logic [10:0] kp_y = '0;
  logic        busy;
  logic [7:0]  rom_a;
  logic [4:0]  rom_spo_x, rom_spo_y;
  logic        smp_valid;
  logic        smp_ready = 1'b1;
  logic [10:0] smp_x, smp_y;
  logic [7:0]  smp_idx;
  logic        smp_oob, smp_last, done;

  desc_offset_walker dut (
    .clk(clk), .rst(rst), .start(start), .kp_x(kp_x), .kp_y(kp_y), .busy(busy),
    .rom_a(rom_a), .rom_spo_x(rom_spo_x), .rom_spo_y(rom_spo_y),
    .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_x(smp_x), .smp_y(smp_y),
    .smp_idx(smp_idx), .smp_oob(smp_oob), .smp_last(smp_last), .done(done)
  );

  always #5 clk = ~clk;

  assign rom_spo_x = {1'b0, rom_a[3:0]} - 5'd8;
  assign rom_spo_y = {1'b0, rom_a[7:4]} - 5'd8;

  typedef struct {
    int idx; int x; int y; bit oob; bit last;
  } smp_t;

  typedef struct {
    string name;
    int kx; int ky; int mode; int restart_at; int rst_at; bit ends;
    int x0; int y0; bit oob0; int x255; int y255; bit oob255;
  } case_t;

  smp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   ready_mode = 0;
  int   hs_count = 0;
  int   done_total = 0;
  int   cap_x[256], cap_y[256], cap_oob[256];

  task automatic check(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic smp_t model(input int kx, input int ky, input int i);
    smp_t m;
    int sx, sy;
    sx = kx + (i % 16) - 8;
    sy = ky + (i / 16) - 8;
    m.idx  = i;
    m.oob  = (sx < 0) || (sx >= 640) || (sy < 0) || (sy >= 480);
    m.last = (i == 255);
    m.x = CLAMP ? clampi(sx, 639) : (sx & 2047);
    m.y = CLAMP ? clampi(sy, 479) : (sy & 2047);
    return m;
  endfunction

  // consumer ready pattern: 0 = always, 1 = alternate, 2 = random (~75%)
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       smp_ready = 1'b1;
      1:       smp_ready = ~smp_ready;
      default: smp_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  bit          stall_prev = 0, last_hs_prev = 0;
  logic [40:0] held;
  smp_t        e;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev   = 0;
      last_hs_prev = 0;
    end else begin
      if (last_hs_prev) begin
        check("done_after_last", done, 1);
        check("busy_in_done", busy, 1);
      end else if (done) begin
        check("spurious_done", done, 0);
      end
      if (done) done_total++;
      if (stall_prev)
        check("hold_stable", {smp_valid, smp_x, smp_y, smp_idx, smp_oob, smp_last, rom_a}, held);
      if (smp_valid && smp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_sample_idx", smp_idx, 999);
        end else begin
          e = exp_q.pop_front();
          check("smp_idx", smp_idx, e.idx);
          check("smp_x", smp_x, e.x);
          check("smp_y", smp_y, e.y);
          check("smp_oob", smp_oob, e.oob);
          check("smp_last", smp_last, e.last);
        end
        cap_x[smp_idx]   = smp_x;
        cap_y[smp_idx]   = smp_y;
        cap_oob[smp_idx] = smp_oob;
        hs_count++;
      end
      stall_prev   = smp_valid && !smp_ready;
      held         = {1'b1, smp_x, smp_y, smp_idx, smp_oob, smp_last, rom_a};
      last_hs_prev = smp_valid && smp_ready && smp_last;
    end
  end

  task automatic run_walk(input case_t c);
    int  hs_base, done_base;
    bit  aborted, restarted;
    ready_mode = c.mode;
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(model(c.kx, c.ky, i));
    @(posedge clk); #2;
    kp_x = 11'(c.kx);
    kp_y = 11'(c.ky);
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    hs_base = hs_count;
    done_base = done_total;
    @(negedge clk);
    check({c.name, "_lat_busy"}, busy, 1);
    check({c.name, "_lat_valid_low"}, smp_valid, 0);
    check({c.name, "_lat_rom_a"}, rom_a, 0);
    @(negedge clk);
    check({c.name, "_lat_valid_high"}, smp_valid, 1);
    check({c.name, "_lat_first_idx"}, smp_idx, 0);
    aborted = 0;
    restarted = 0;
    for (int cyc = 0; cyc < 4000 && done_total == done_base && !aborted; cyc++) begin
      @(posedge clk); #2;
      start = 1'b0;
      if (c.restart_at >= 0 && !restarted && (hs_count - hs_base) >= c.restart_at) begin
        start = 1'b1;
        kp_x = 11'd5;
        kp_y = 11'd7;
        restarted = 1;
      end
      if (c.rst_at >= 0 && (hs_count - hs_base) >= c.rst_at) begin
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        check({c.name, "_rst_valid"}, smp_valid, 0);
        check({c.name, "_rst_busy"}, busy, 0);
        check({c.name, "_rst_rom_a"}, rom_a, 0);
        exp_q.delete();
        aborted = 1;
      end
    end
    start = 1'b0;
    if (!aborted) begin
      check({c.name, "_done_seen"}, done_total - done_base, 1);
      check({c.name, "_all_samples"}, exp_q.size(), 0);
      @(negedge clk);
      check({c.name, "_busy_after"}, busy, 0);
      check({c.name, "_done_one_cycle"}, done_total - done_base, 1);
      if (c.ends) begin
        check({c.name, "_x0"}, cap_x[0], c.x0);
        check({c.name, "_y0"}, cap_y[0], c.y0);
        check({c.name, "_oob0"}, cap_oob[0], c.oob0);
        check({c.name, "_x255"}, cap_x[255], c.x255);
        check({c.name, "_y255"}, cap_y[255], c.y255);
        check({c.name, "_oob255"}, cap_oob[255], c.oob255);
      end
    end
  endtask

  case_t tbl[6];

  initial begin
    tbl[0] = '{"t1_nominal", 100, 50, 0, -1, -1, 1, 92, 42, 0, 107, 57, 0};
    tbl[1] = '{"t2_underflow", 3, 2, 0, -1, -1, 1,
               CLAMP ? 0 : 2043, CLAMP ? 0 : 2042, 1, 10, 9, 0};
    tbl[2] = '{"t3_toggle", 100, 50, 1, -1, -1, 1, 92, 42, 0, 107, 57, 0};
    tbl[3] = '{"t4_restart", 100, 50, 2, 10, -1, 1, 92, 42, 0, 107, 57, 0};
    tbl[4] = '{"t5_reset", 100, 50, 0, -1, 40, 0, 0, 0, 0, 0, 0, 0};
    tbl[5] = '{"t6_overflow", 636, 478, 0, -1, -1, 1, 628, 470, 0,
               CLAMP ? 639 : 643, CLAMP ? 479 : 485, 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", smp_valid, 0);
    check("rst_rom_a", rom_a, 0);
    check("rst_x", smp_x, 0);
    check("rst_y", smp_y, 0);
    check("rst_idx", smp_idx, 0);
    check("rst_oob", smp_oob, 0);
    check("rst_last", smp_last, 0);
    check("rst_done", done, 0);
    @(posedge clk); #2;
    rst = 1'b0;

    for (int t = 0; t < 6; t++) run_walk(tbl[t]);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
